// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes IF/ID into ALU control, registers operands and control
// into EX, forwards EX/MEM and MEM/WB results onto the ALU inputs, and detects load-use hazards.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic             flush,
    input  logic             exmem_regwrite,
    input  logic             memwb_regwrite,
    input  logic [RW-1:0]    exmem_rd,
    input  logic [RW-1:0]    memwb_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] memwb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] entr1,
    output logic [WIDTH-1:0] entr2,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [WIDTH-1:0] ex_imm,
    output logic [RW-1:0]    ex_wreg,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch
);

    typedef enum logic [1:0] {SRC_RT = 2'd0, SRC_IMM = 2'd1, SRC_ZERO = 2'd2} src2_e;

    typedef struct packed {
        logic             valid;
        logic [3:0]       alu;
        logic [RW-1:0]    rs;
        logic [RW-1:0]    rt;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm_sext;
        logic [WIDTH-1:0] imm_op;
        src2_e            src2;
        logic [RW-1:0]    wreg;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             branch;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, dec;
    logic    dec_ok, dec_rt_src, dec_zext;

    always_comb begin
        dec        = '0;
        dec_ok     = 1'b0;
        dec_rt_src = 1'b0;
        dec_zext   = 1'b0;
        dec.src2   = SRC_IMM;
        case (id_opcode)
            6'b000000: begin
                dec_ok = 1'b1; dec_rt_src = 1'b1;
                dec.src2 = SRC_RT; dec.wreg = id_rd; dec.regwrite = 1'b1;
                case (id_funct)
                    6'b100000: dec.alu = 4'b0000;
                    6'b100010: dec.alu = 4'b0001;
                    6'b100100: dec.alu = 4'b0010;
                    6'b100111: dec.alu = 4'b0011;
                    6'b100101: dec.alu = 4'b0100;
                    6'b101010: dec.alu = 4'b0101;
                    default:   dec_ok  = 1'b0;
                endcase
            end
            6'b001000: begin dec_ok = 1'b1; dec.alu = 4'b0000; dec.wreg = id_rt; dec.regwrite = 1'b1; end
            6'b001100: begin dec_ok = 1'b1; dec.alu = 4'b0010; dec.wreg = id_rt; dec.regwrite = 1'b1; dec_zext = 1'b1; end
            6'b001101: begin dec_ok = 1'b1; dec.alu = 4'b0100; dec.wreg = id_rt; dec.regwrite = 1'b1; dec_zext = 1'b1; end
            6'b001010: begin dec_ok = 1'b1; dec.alu = 4'b0101; dec.wreg = id_rt; dec.regwrite = 1'b1; end
            6'b100011: begin
                dec_ok = 1'b1; dec.wreg = id_rt; dec.regwrite = 1'b1;
                dec.memread = 1'b1; dec.memtoreg = 1'b1;
            end
            6'b101011: begin dec_ok = 1'b1; dec_rt_src = 1'b1; dec.memwrite = 1'b1; end
            6'b000100: begin dec_ok = 1'b1; dec_rt_src = 1'b1; dec.alu = 4'b0110; dec.branch = 1'b1; dec.src2 = SRC_RT; end
            6'b000101: begin dec_ok = 1'b1; dec_rt_src = 1'b1; dec.alu = 4'b0111; dec.branch = 1'b1; dec.src2 = SRC_RT; end
            6'b000001: begin
                dec_ok = (id_rt == RW'(1));
                dec.alu = 4'b1111; dec.branch = 1'b1; dec.src2 = SRC_ZERO;
            end
            default: dec_ok = 1'b0;
        endcase
        // Register 0 is hardwired, so a write to it is no write at all.
        if (dec.wreg == '0)
            dec.regwrite = 1'b0;
        dec.valid    = 1'b1;
        dec.rs       = id_rs;
        dec.rt       = id_rt;
        dec.rs_data  = id_rs_data;
        dec.rt_data  = id_rt_data;
        dec.imm_sext = {{(WIDTH-16){id_imm[15]}}, id_imm};
        dec.imm_op   = dec_zext ? {{(WIDTH-16){1'b0}}, id_imm} : dec.imm_sext;
    end

    always_comb begin
        stall = 1'b0;
        if (ex_q.valid && ex_q.memread && ex_q.wreg != '0 && id_valid && !flush)
            stall = (ex_q.wreg == id_rs) || (dec_rt_src && ex_q.wreg == id_rt);
    end

    always_comb begin
        ex_d = '0;
        if (!flush && !stall && id_valid && dec_ok)
            ex_d = dec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    function automatic logic [WIDTH-1:0] fwd(
        input logic [RW-1:0]    r,
        input logic [WIDTH-1:0] v,
        input logic             em_we,
        input logic [RW-1:0]    em_rd,
        input logic [WIDTH-1:0] em_res,
        input logic             mw_we,
        input logic [RW-1:0]    mw_rd,
        input logic [WIDTH-1:0] mw_res
    );
        if (em_we && em_rd != '0 && em_rd == r)
            return em_res;
        else if (mw_we && mw_rd != '0 && mw_rd == r)
            return mw_res;
        else
            return v;
    endfunction

    logic [WIDTH-1:0] rs_fwd, rt_fwd;

    assign rs_fwd = fwd(ex_q.rs, ex_q.rs_data, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);
    assign rt_fwd = fwd(ex_q.rt, ex_q.rt_data, exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result);

    always_comb begin
        case (ex_q.src2)
            SRC_RT:  entr2 = rt_fwd;
            SRC_IMM: entr2 = ex_q.imm_op;
            default: entr2 = '0;
        endcase
    end

    assign entr1         = rs_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = ex_q.valid;
    assign alu_ctrl      = ex_q.alu;
    assign ex_imm        = ex_q.imm_sext;
    assign ex_wreg       = ex_q.wreg;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_memtoreg   = ex_q.memtoreg;
    assign ex_branch     = ex_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: decode, forwarding, load-use stall, flush and reset.
module tb_id_ex_stage;
    localparam int WIDTH = 32;
    localparam int RW    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [5:0]       id_opcode, id_funct;
    logic [RW-1:0]    id_rs, id_rt, id_rd;
    logic [WIDTH-1:0] id_rs_data, id_rt_data;
    logic [15:0]      id_imm;
    logic             flush;
    logic             exmem_regwrite, memwb_regwrite;
    logic [RW-1:0]    exmem_rd, memwb_rd;
    logic [WIDTH-1:0] exmem_result, memwb_result;
    logic             stall, ex_valid;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] entr1, entr2, ex_store_data, ex_imm;
    logic [RW-1:0]    ex_wreg;
    logic             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_result(exmem_result),
        .memwb_result(memwb_result), .stall(stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
        .entr1(entr1), .entr2(entr2), .ex_store_data(ex_store_data), .ex_imm(ex_imm),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [5:0] op, input logic [5:0] fn, input int rs, input int rt,
                            input int rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [15:0] imm);
        id_valid = 1'b1; id_opcode = op; id_funct = fn;
        id_rs = RW'(rs); id_rt = RW'(rt); id_rd = RW'(rd);
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        #1;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        exmem_rd = '0; memwb_rd = '0; exmem_result = '0; memwb_result = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; clear_fwd();
        drive_id(6'b000000, 6'b100000, 1, 2, 3, 32'h11, 32'h22, 16'h0);
        tick(); tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
        checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_alu got=%0h exp=0", alu_ctrl); end
        checks++; if ({entr1, entr2, ex_store_data, ex_imm} !== '0) begin errors++; $display("FAIL reset_data got=%0h %0h %0h %0h exp=0", entr1, entr2, ex_store_data, ex_imm); end
        checks++; if ({ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch} !== '0) begin errors++; $display("FAIL reset_ctrl got=%0h exp=0", {ex_wreg, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        drive_id(6'b001000, 6'b000000, 1, 5, 0, 32'h7, 32'h0, 16'hFFFC);
        tick();
        checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL addi_alu got=%0h exp=0", alu_ctrl); end
        checks++; if (entr2 !== 32'hFFFFFFFC) begin errors++; $display("FAIL addi_entr2 got=%0h exp=fffffffc", entr2); end
        checks++; if (ex_wreg !== 5'd5 || ex_regwrite !== 1'b1) begin errors++; $display("FAIL addi_wreg got=%0d/%0b exp=5/1", ex_wreg, ex_regwrite); end
        checks++; if (entr1 !== 32'h7 || ex_valid !== 1'b1) begin errors++; $display("FAIL addi_entr1 got=%0h/%0b exp=7/1", entr1, ex_valid); end
        drive_id(6'b001100, 6'b000000, 1, 6, 0, 32'h7, 32'h0, 16'hFFFC);
        tick();
        checks++; if (entr2 !== 32'h0000FFFC) begin errors++; $display("FAIL andi_entr2 got=%0h exp=0000fffc", entr2); end
        checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL andi_alu got=%0h exp=2", alu_ctrl); end
        checks++; if (ex_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL andi_ex_imm got=%0h exp=fffffffc", ex_imm); end
        drive_id(6'b000000, 6'b100010, 2, 3, 4, 32'h30, 32'h12, 16'h0);
        tick();
        checks++; if (alu_ctrl !== 4'b0001 || entr2 !== 32'h12 || ex_wreg !== 5'd4) begin errors++; $display("FAIL sub_decode got=%0h/%0h/%0d exp=1/12/4", alu_ctrl, entr2, ex_wreg); end
        drive_id(6'b001000, 6'b000000, 1, 0, 0, 32'h7, 32'h0, 16'h0001);
        tick();
        checks++; if (ex_regwrite !== 1'b0 || ex_valid !== 1'b1) begin errors++; $display("FAIL addi_r0 got=%0b/%0b exp=0/1", ex_regwrite, ex_valid); end
        drive_id(6'b101011, 6'b000000, 1, 4, 0, 32'h100, 32'h99, 16'h0008);
        tick();
        checks++; if (ex_memwrite !== 1'b1 || ex_regwrite !== 1'b0 || entr2 !== 32'h8 || ex_store_data !== 32'h99) begin errors++; $display("FAIL sw_decode got=%0b/%0b/%0h/%0h exp=1/0/8/99", ex_memwrite, ex_regwrite, entr2, ex_store_data); end
    endtask

    task automatic test_forwarding();
        clear_fwd();
        drive_id(6'b000000, 6'b100000, 3, 4, 9, 32'h1, 32'h2, 16'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
        #1;
        checks++; if (entr1 !== 32'h10) begin errors++; $display("FAIL fwd_exmem got=%0h exp=10", entr1); end
        exmem_regwrite = 1'b0; #1;
        checks++; if (entr1 !== 32'h20) begin errors++; $display("FAIL fwd_memwb got=%0h exp=20", entr1); end
        memwb_rd = 5'd4; #1;
        checks++; if (entr1 !== 32'h1 || entr2 !== 32'h20) begin errors++; $display("FAIL fwd_rt got=%0h/%0h exp=1/20", entr1, entr2); end
        clear_fwd();
        drive_id(6'b000000, 6'b100000, 0, 4, 9, 32'h5, 32'h2, 16'h0);
        tick();
        exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h10;
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h20;
        #1;
        checks++; if (entr1 !== 32'h5) begin errors++; $display("FAIL fwd_r0 got=%0h exp=5", entr1); end
        clear_fwd();
    endtask

    task automatic test_load_use();
        clear_fwd();
        drive_id(6'b100011, 6'b000000, 1, 8, 0, 32'h100, 32'h0, 16'h0004);
        tick();
        checks++; if (ex_memread !== 1'b1 || ex_wreg !== 5'd8 || ex_memtoreg !== 1'b1) begin errors++; $display("FAIL lw_decode got=%0b/%0d/%0b exp=1/8/1", ex_memread, ex_wreg, ex_memtoreg); end
        drive_id(6'b000000, 6'b100000, 8, 2, 10, 32'hAA, 32'h3, 16'h0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || alu_ctrl !== 4'h0) begin errors++; $display("FAIL lu_bubble got=%0b/%0b/%0h exp=0/0/0", ex_valid, ex_regwrite, alu_ctrl); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got=%0b exp=0", stall); end
        tick();
        memwb_regwrite = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h55; #1;
        checks++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd10 || entr1 !== 32'h55) begin errors++; $display("FAIL lu_reissue got=%0b/%0d/%0h exp=1/10/55", ex_valid, ex_wreg, entr1); end
        clear_fwd();
        drive_id(6'b100011, 6'b000000, 1, 8, 0, 32'h100, 32'h0, 16'h0004);
        tick();
        drive_id(6'b001000, 6'b000000, 1, 8, 0, 32'h1, 32'h0, 16'h0001);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_not_src got=%0b exp=0", stall); end
        drive_id(6'b000000, 6'b100000, 1, 8, 12, 32'h1, 32'h0, 16'h0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_src got=%0b exp=1", stall); end
        rst_n = 1'b0;
        tick();
        checks++; if (stall !== 1'b0 || ex_memread !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_stall got=%0b/%0b/%0b exp=0/0/0", stall, ex_memread, ex_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_flush();
        drive_id(6'b100011, 6'b000000, 1, 8, 0, 32'h100, 32'h0, 16'h0004);
        tick();
        drive_id(6'b000000, 6'b100010, 8, 2, 11, 32'h1, 32'h2, 16'h0);
        flush = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", stall); end
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_wreg !== 5'd0 || ex_memread !== 1'b0) begin errors++; $display("FAIL flush_bubble got=%0b/%0b/%0d/%0b exp=0/0/0/0", ex_valid, ex_regwrite, ex_wreg, ex_memread); end
    endtask

    task automatic test_branch_unknown();
        drive_id(6'b000001, 6'b000000, 2, 1, 0, 32'h5, 32'h77, 16'h0010);
        tick();
        checks++; if (alu_ctrl !== 4'b1111 || entr2 !== 32'h0 || ex_branch !== 1'b1) begin errors++; $display("FAIL bgez got=%0h/%0h/%0b exp=f/0/1", alu_ctrl, entr2, ex_branch); end
        checks++; if (ex_imm !== 32'h10 || ex_regwrite !== 1'b0 || entr1 !== 32'h5) begin errors++; $display("FAIL bgez_ops got=%0h/%0b/%0h exp=10/0/5", ex_imm, ex_regwrite, entr1); end
        drive_id(6'b000100, 6'b000000, 2, 3, 0, 32'h5, 32'h6, 16'hFFFE);
        tick();
        checks++; if (alu_ctrl !== 4'b0110 || entr2 !== 32'h6 || ex_imm !== 32'hFFFFFFFE) begin errors++; $display("FAIL beq got=%0h/%0h/%0h exp=6/6/fffffffe", alu_ctrl, entr2, ex_imm); end
        drive_id(6'b111111, 6'b100000, 1, 2, 3, 32'h5, 32'h6, 16'h1);
        tick();
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 4'h0 || ex_regwrite !== 1'b0 || ex_branch !== 1'b0) begin errors++; $display("FAIL unknown got=%0b/%0h/%0b/%0b exp=0/0/0/0", ex_valid, alu_ctrl, ex_regwrite, ex_branch); end
        drive_id(6'b000001, 6'b000000, 2, 0, 0, 32'h5, 32'h0, 16'h1);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_branch !== 1'b0) begin errors++; $display("FAIL bgez_bad_rt got=%0b/%0b exp=0/0", ex_valid, ex_branch); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_forwarding();
        test_load_use();
        test_flush();
        test_branch_unknown();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS datapath, sitting directly upstream of the ALU. It decodes the instruction held in IF/ID into control signals and the 4-bit ALU operation code. It registers operands and control into the EX stage and forwards results from EX/MEM and MEM/WB onto the ALU inputs. It also detects load-use hazards and inserts bubbles, and turns instructions into bubbles on a branch flush.

## Interface
Parameters:
- WIDTH, 32, datapath width
- RW, 5, register-number width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  6  instruction[31:26]
- id_funct  in  6  instruction[5:0]
- id_rs, id_rt, id_rd  in  RW  register fields
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  16  instruction[15:0]
- flush  in  1  taken branch resolved downstream; squash ID
- exmem_regwrite, memwb_regwrite  in  1  downstream write enables
- exmem_rd, memwb_rd  in  RW  downstream destination registers
- exmem_result, memwb_result  in  WIDTH  downstream results
- stall  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  EX holds a real instruction
- alu_ctrl  out  4  ALU operation (registered)
- entr1, entr2  out  WIDTH  ALU operands after forwarding (combinational from registered state)
- ex_store_data  out  WIDTH  forwarded rt value for sw
- ex_imm  out  WIDTH  extended immediate (branch offset)
- ex_wreg  out  RW  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1  registered control

## Operation
Decode rules (opcode/funct → alu_ctrl, wreg, entr2 source):
- R-type (000000), wreg=rd, entr2=rt: add 100000→0000, sub 100010→0001, and 100100→0010, nor 100111→0011, or 100101→0100, slt 101010→0101.
- I-type arithmetic, wreg=rt, entr2=imm: addi 001000→0000, andi 001100→0010, ori 001101→0100, slti 001010→0101.
- lw 100011: 0000, memread, memtoreg, regwrite, wreg=rt, entr2=imm.
- sw 101011: 0000, memwrite, entr2=imm, store data=rt.
- beq 000100→0110, bne 000101→0111: branch, entr2=rt.
- bgez 000001 with rt=00001→1111: branch, entr2=0.
- Any other encoding is loaded as a bubble.
- andi and ori zero-extend the immediate; all others sign-extend. ex_imm always holds the sign-extended value.
- A write to register 0 forces regwrite=0.
- rt is a source only for R-type, sw, beq and bne.

Bubble:
- ex_valid, regwrite, memread, memwrite, memtoreg and branch are all 0.
- alu_ctrl=0000, ex_wreg=0.

Load-use hazard:
- stall=1 when ex_valid & ex_memread & ex_wreg≠0, and ex_wreg matches id_rs, or matches id_rt where rt is a source, and id_valid=1 and flush=0.
- On stall the register loads a bubble.

Priority at each clock edge:
- rst_n=0: all registers cleared.
- Else flush=1: bubble is loaded and stall is forced to 0.
- Else stall=1: bubble is loaded.
- Else id_valid=1: the decoded instruction is loaded.
- Else: bubble is loaded.

Forwarding, applied separately to the registered rs value and the registered rt value:
- EX/MEM result is used when exmem_regwrite, exmem_rd≠0 and exmem_rd matches.
- Otherwise MEM/WB result is used when memwb_regwrite, memwb_rd≠0 and memwb_rd matches.
- Otherwise the registered value is used.
- EX/MEM takes priority when both match.
- The forwarded rt value drives ex_store_data and, when the entr2 source is rt, entr2.

## Timing
- All outputs reset to 0 on the first edge with rst_n=0, including alu_ctrl=0000.
- Latency is one cycle from the ID inputs to the registered EX outputs.
- entr1, entr2 and ex_store_data change in the same cycle as the exmem_*/memwb_* inputs.
- stall is combinational in the same cycle. The upstream block must hold IF/ID while stall=1, so the stalled instruction re-enters the next cycle.
- A load followed directly by a dependent instruction gives exactly one stall cycle. The second cycle is served by MEM/WB forwarding.
- Reset takes effect mid-stall and mid-flush: the register is cleared and stall drops once ex_memread=0.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with a valid add in ID → every output is 0 and stall=0.
- Decode: addi rt=5, imm=0xFFFC → next cycle alu_ctrl=0000, entr2=0xFFFFFFFC, ex_wreg=5, ex_regwrite=1. andi with imm=0xFFFC → entr2=0x0000FFFC, alu_ctrl=0010.
- Forwarding: EX add with rs=3 and registered value 1; exmem_rd=3 with result 0x10; memwb_rd=3 with result 0x20 → entr1=0x10. Drop exmem_regwrite → entr1=0x20. Set rs=0 with both matching → no forwarding.
- Load-use: EX holds lw with wreg=8; ID holds add with rs=8 → stall=1 and the next cycle is a bubble. Then stall=0, the add loads, and forwarding is taken from memwb_result.
- Flush: flush=1 with a valid sub in ID and a load-use condition present → stall=0, a bubble is loaded, and ex_valid=0 next cycle.
- bgez with rt=1 → alu_ctrl=1111, entr2=0, ex_branch=1. Unknown opcode 111111 → bubble.
